// File: rtl/mps_axil_pkg.sv
// Shared types and constants for the MPS AXI4-Lite command master.
package mps_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mps_axil_cmd_master_if.sv
// AXI4-Lite channel bundle between the command master and the MPS System slave.
interface mps_axil_cmd_master_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mps_axil_timeout.sv
// Per-transaction watchdog: cleared on command accept, counts while enabled,
// flags expiry once it reaches C_TIMEOUT-1 and holds there.
module mps_axil_timeout #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int CW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(C_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expire = (cnt_q == TC);

  // Next count: clear wins, otherwise count up until terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mps_axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
//
// state   | meaning
// IDLE    | ready for a command
// WR_AW_W | write address/data offered; AW and W retire independently
// WR_B    | waiting for write response
// RD_AR   | read address offered
// RD_R    | waiting for read data
// DONE    | one-cycle response pulse (normal or timeout)
module mps_axil_cmd_master
  import mps_axil_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 7,
  parameter int          C_TIMEOUT          = 1024,
  parameter logic [15:0] C_ERR_CNT_RST      = 16'h0000
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                            o_rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_rsp_timeout,
  output logic                            o_busy,
  output logic [15:0]                     o_err_cnt,
  mps_axil_cmd_master_if.master           m00_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  state_e          state_q, state_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            abort;
  logic            to_clear, to_enable, to_expire;
  logic            unused_addr_lsb;

  // Word-aligned bus addresses only; the low byte-lane bits are dropped.
  assign unused_addr_lsb = ^i_cmd_addr[1:0];

  assign to_enable = (state_q == WR_AW_W) || (state_q == WR_B) ||
                     (state_q == RD_AR)   || (state_q == RD_R);

  mps_axil_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (to_clear),
    .i_enable (to_enable),
    .o_expire (to_expire)
  );

  // Next-state, command latch, response capture and error accounting.
  always_comb begin
    state_d       = state_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    err_cnt_d     = err_cnt_q;
    to_clear      = 1'b0;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          to_clear = 1'b1;
          addr_d   = {i_cmd_addr[AW-1:2], 2'b00};
          wdata_d  = i_cmd_wdata;
          wstrb_d  = i_cmd_wstrb;
          if (i_cmd_write) begin
            state_d    = WR_AW_W;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        aw_valid_d = aw_valid_q & ~m00_axi.awready;
        w_valid_d  = w_valid_q & ~m00_axi.wready;
        if (!aw_valid_d && !w_valid_d) state_d = WR_B;
        else if (to_expire)            abort   = 1'b1;
      end
      WR_B: begin
        if (m00_axi.bvalid) begin
          state_d       = DONE;
          rsp_data_d    = '0;
          rsp_resp_d    = m00_axi.bresp;
          rsp_timeout_d = 1'b0;
        end else if (to_expire) begin
          abort = 1'b1;
        end
      end
      RD_AR: begin
        if (m00_axi.arready) state_d = RD_R;
        else if (to_expire)  abort   = 1'b1;
      end
      RD_R: begin
        if (m00_axi.rvalid) begin
          state_d       = DONE;
          rsp_data_d    = m00_axi.rdata;
          rsp_resp_d    = m00_axi.rresp;
          rsp_timeout_d = 1'b0;
        end else if (to_expire) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (rsp_resp_q != RESP_OKAY) err_cnt_d = sat_inc16(err_cnt_q);
      end
      default: state_d = IDLE;
    endcase

    // Watchdog expiry without a completing handshake ends the transfer.
    if (abort) begin
      state_d       = DONE;
      aw_valid_d    = 1'b0;
      w_valid_d     = 1'b0;
      rsp_data_d    = '0;
      rsp_resp_d    = RESP_TIMEOUT;
      rsp_timeout_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= IDLE;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
      err_cnt_q     <= C_ERR_CNT_RST;
    end else begin
      state_q       <= state_d;
      aw_valid_q    <= aw_valid_d;
      w_valid_q     <= w_valid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign o_cmd_ready   = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_rsp_valid   = (state_q == DONE);
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_err_cnt     = err_cnt_q;

  assign m00_axi.awaddr  = addr_q;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awvalid = aw_valid_q;
  assign m00_axi.wdata   = wdata_q;
  assign m00_axi.wstrb   = wstrb_q;
  assign m00_axi.wvalid  = w_valid_q;
  assign m00_axi.bready  = (state_q == WR_B);
  assign m00_axi.araddr  = addr_q;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = (state_q == RD_AR);
  assign m00_axi.rready  = (state_q == RD_R);
endmodule

// File: tb/tb_mps_axil_cmd_master.sv
// Directed bench for mps_axil_cmd_master: main instance with a short watchdog,
// plus a second instance whose error counter starts saturated.
module tb_mps_axil_cmd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic        cmd_valid, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_ready, rsp_valid, rsp_timeout, busy;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [15:0] err_cnt;

  logic        s_cmd_valid, s_cmd_write;
  logic [6:0]  s_cmd_addr;
  logic [31:0] s_cmd_wdata;
  logic [3:0]  s_cmd_wstrb;
  logic        s_cmd_ready, s_rsp_valid, s_rsp_timeout, s_busy;
  logic [31:0] s_rsp_data;
  logic [1:0]  s_rsp_resp;
  logic [15:0] s_err_cnt;

  int n;

  mps_axil_cmd_master_if #(.AW(7), .DW(32)) axi ();
  mps_axil_cmd_master_if #(.AW(7), .DW(32)) axi_s ();

  mps_axil_cmd_master #(.C_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_resp(rsp_resp),
    .o_rsp_timeout(rsp_timeout), .o_busy(busy), .o_err_cnt(err_cnt),
    .m00_axi(axi)
  );

  mps_axil_cmd_master #(.C_TIMEOUT(16), .C_ERR_CNT_RST(16'hFFFF)) dut_s (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(s_cmd_valid), .o_cmd_ready(s_cmd_ready), .i_cmd_write(s_cmd_write),
    .i_cmd_addr(s_cmd_addr), .i_cmd_wdata(s_cmd_wdata), .i_cmd_wstrb(s_cmd_wstrb),
    .o_rsp_valid(s_rsp_valid), .o_rsp_data(s_rsp_data), .o_rsp_resp(s_rsp_resp),
    .o_rsp_timeout(s_rsp_timeout), .o_busy(s_busy), .o_err_cnt(s_err_cnt),
    .m00_axi(axi_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns one time unit after the accept edge.
  task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    s_cmd_valid = 1'b0; s_cmd_write = 1'b0; s_cmd_addr = '0; s_cmd_wdata = '0; s_cmd_wstrb = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    axi_s.awready = 1'b1; axi_s.wready = 1'b1; axi_s.bvalid = 1'b1; axi_s.bresp = 2'b10;
    axi_s.arready = 1'b1; axi_s.rvalid = 1'b1; axi_s.rdata = '0; axi_s.rresp = 2'b10;
    step(); step(); step();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_handshakes", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("rst_sat_err_cnt", s_err_cnt, 16'hFFFF);
    rst = 1'b1;
    step();

    // Write 0x08 <- 1, AW and W ready together, B one cycle later
    axi.awready = 1'b1; axi.wready = 1'b1;
    issue(1'b1, 7'h08, 32'h1);
    chk("wr1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    chk("wr1_awaddr", axi.awaddr, 7'h08);
    chk("wr1_wdata", axi.wdata, 32'h1);
    chk("wr1_cmd_ready_busy", cmd_ready, 0);
    step();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("wr1_bphase", {axi.awvalid, axi.wvalid, axi.bready, rsp_valid}, 4'b0010);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step();
    axi.bvalid = 1'b0;
    chk("wr1_rsp_valid", rsp_valid, 1);
    chk("wr1_rsp", {rsp_timeout, rsp_resp, rsp_data}, 35'h0);
    step();
    chk("wr1_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
    chk("wr1_err_cnt", err_cnt, 0);

    // Write with W taken three cycles before AW
    axi.wready = 1'b1;
    issue(1'b1, 7'h10, 32'hA5A5_0001);
    step();
    axi.wready = 1'b0;
    chk("wr2_w_dropped", {axi.awvalid, axi.wvalid}, 2'b10);
    step(); step();
    chk("wr2_aw_held", {axi.awvalid, axi.wvalid, axi.awaddr}, {2'b10, 7'h10});
    axi.awready = 1'b1;
    step();
    axi.awready = 1'b0;
    chk("wr2_bphase", {axi.awvalid, axi.bready}, 2'b01);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step();
    axi.bvalid = 1'b0;
    chk("wr2_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);
    step();
    chk("wr2_single_b", {rsp_valid, axi.bready, cmd_ready}, 3'b001);

    // Read 0x0F (aligned to 0x0C), two arready wait cycles, rdata 5
    issue(1'b0, 7'h0F, 32'h0);
    chk("rd_araddr", {axi.arvalid, axi.araddr}, {1'b1, 7'h0C});
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h20;
    step();
    chk("rd_busy_reject", {cmd_ready, axi.arvalid, axi.awvalid}, 3'b010);
    step();
    cmd_valid = 1'b0;
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    chk("rd_rphase", {axi.arvalid, axi.rready}, 2'b01);
    axi.rvalid = 1'b1; axi.rdata = 32'h0000_0005; axi.rresp = 2'b00;
    step();
    axi.rvalid = 1'b0; axi.rdata = 32'hDEAD_BEEF;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 32'h5);
    chk("rd_rsp_resp", rsp_resp, 0);
    step();
    chk("rd_data_held", {rsp_valid, rsp_data}, {1'b0, 32'h5});

    // Read to a slave that never asserts arready: watchdog of 16 cycles
    issue(1'b0, 7'h04, 32'h0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_arvalid_dropped", axi.arvalid, 0);
    chk("to_rsp", {rsp_timeout, rsp_resp, rsp_data}, {1'b1, 2'b11, 32'h0});
    step();
    chk("to_err_cnt", err_cnt, 1);

    // Write answered with SLVERR
    axi.awready = 1'b1; axi.wready = 1'b1;
    issue(1'b1, 7'h14, 32'h2);
    step();
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    step();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chk("slverr_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1010);
    step();
    chk("slverr_err_cnt", err_cnt, 2);

    // Saturated counter instance with a SLVERR write
    s_cmd_valid = 1'b1; s_cmd_write = 1'b1; s_cmd_addr = 7'h10; s_cmd_wdata = 32'h3; s_cmd_wstrb = 4'hF;
    step();
    s_cmd_valid = 1'b0;
    step(); step();
    chk("sat_rsp", {s_rsp_valid, s_rsp_resp}, 3'b110);
    step();
    chk("sat_err_cnt_held", s_err_cnt, 16'hFFFF);

    // Reset while awvalid is high
    issue(1'b1, 7'h08, 32'h7);
    chk("mrst_pre_awvalid", axi.awvalid, 1);
    rst = 1'b0;
    step();
    chk("mrst_handshakes", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("mrst_outputs", {busy, rsp_valid, rsp_timeout, rsp_resp}, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    rst = 1'b1;
    step();
    chk("mrst_cmd_ready", {cmd_ready, busy}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
